// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the clkoutd-domain power-on reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      SETTLE,
      STAGE,
      HOLD,
      RUN
   } state_e;

   localparam int unsigned DEF_N_STAGES        = 3;
   localparam int unsigned DEF_SETTLE_CYCLES   = 7776;
   localparam int unsigned DEF_STAGE_GAP       = 16;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1024;
   localparam int unsigned DEF_HOLD_CYCLES     = 64;

   localparam int unsigned           RST_CNT_W   = 8;
   localparam logic [RST_CNT_W-1:0]  RST_CNT_MAX = 8'd255;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/rst_seq_debounce_sync.sv
// Two-flop synchroniser followed by a level debouncer; the output only moves
// once the synchronised input has disagreed with it for DEBOUNCE_CYCLES edges.
module debounce_sync
   import rst_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic        INIT            = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic dout_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Flip happens on the edge after the DEBOUNCE_CYCLES-th disagreeing sample.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) level_d = sync2_q;
         else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= INIT;
         sync2_q <= INIT;
         level_q <= INIT;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout_o = level_q;

endmodule

// File: rtl/rst_seq.sv
// Power-on reset sequencer: clock-settle wait, then staged release of rst_out,
// re-run on a debounced button or a software request.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_STAGES        = DEF_N_STAGES,
   parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
   parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ext_rst_n,
   input  logic                 sw_rst_req,
   output logic [N_STAGES-1:0]  rst_out,
   output logic                 ready,
   output logic [RST_CNT_W-1:0] rst_count
);

   localparam int unsigned CNT_MAX = max3(SETTLE_CYCLES, STAGE_GAP, HOLD_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_STAGES - 1);
   localparam logic [N_STAGES-1:0] BIT0     = N_STAGES'(1);

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic [N_STAGES-1:0]    rst_out_q;
   logic                   ready_q;
   logic [RST_CNT_W-1:0]   rst_count_q;
   logic [RST_CNT_W-1:0]   count_inc;
   logic                   btn_n;
   logic                   req;

   debounce_sync #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT            (1'b1)
   ) u_debounce (
      .clk_i  (clk),
      .rst_i  (rst),
      .din_i  (ext_rst_n),
      .dout_o (btn_n)
   );

   assign req       = sw_rst_req | ~btn_n;
   assign count_inc = (rst_count_q == RST_CNT_MAX) ? rst_count_q
                                                   : rst_count_q + RST_CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SETTLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_out_q   <= '1;
         ready_q     <= 1'b0;
         rst_count_q <= '0;
      end else begin
         case (state_q)
            SETTLE: begin
               if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                  cnt_q <= '0;
                  if (N_STAGES == 1) begin
                     rst_out_q   <= '0;
                     ready_q     <= 1'b1;
                     rst_count_q <= count_inc;
                     state_q     <= RUN;
                  end else begin
                     rst_out_q <= ~BIT0;
                     idx_q     <= IDX_W'(1);
                     state_q   <= STAGE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            // A request beats a release landing on the same edge.
            STAGE: begin
               if (req) begin
                  rst_out_q <= '1;
                  ready_q   <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= HOLD;
               end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                  cnt_q     <= '0;
                  rst_out_q <= rst_out_q & ~(BIT0 << idx_q);
                  if (idx_q == LAST_IDX) begin
                     ready_q     <= 1'b1;
                     rst_count_q <= count_inc;
                     state_q     <= RUN;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            HOLD: begin
               if (!btn_n) begin
                  cnt_q <= '0;
               end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  cnt_q <= '0;
                  if (N_STAGES == 1) begin
                     rst_out_q   <= '0;
                     ready_q     <= 1'b1;
                     rst_count_q <= count_inc;
                     state_q     <= RUN;
                  end else begin
                     rst_out_q <= ~BIT0;
                     idx_q     <= IDX_W'(1);
                     state_q   <= STAGE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            RUN: begin
               if (req) begin
                  rst_out_q <= '1;
                  ready_q   <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= HOLD;
               end
            end

            default: state_q <= SETTLE;
         endcase
      end
   end

   assign rst_out   = rst_out_q;
   assign ready     = ready_q;
   assign rst_count = rst_count_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with short settle/gap/debounce/hold intervals.
`timescale 1ns/1ps
module tb_rst_seq;

   localparam int unsigned NS = 3;
   localparam int unsigned SC = 20;
   localparam int unsigned SG = 4;
   localparam int unsigned DC = 8;
   localparam int unsigned HC = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_rst_n;
   logic       sw_rst_req;
   logic [2:0] rst_out;
   logic       ready;
   logic [7:0] rst_count;

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   always #5 clk = ~clk;

   rst_seq #(
      .N_STAGES        (NS),
      .SETTLE_CYCLES   (SC),
      .STAGE_GAP       (SG),
      .DEBOUNCE_CYCLES (DC),
      .HOLD_CYCLES     (HC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ext_rst_n  (ext_rst_n),
      .sw_rst_req (sw_rst_req),
      .rst_out    (rst_out),
      .ready      (ready),
      .rst_count  (rst_count)
   );

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected rst_out at edge j when bit 0 is released at edge r0.
   function automatic logic [2:0] rel_pattern(input int j, input int r0);
      if (j < r0)          return 3'b111;
      else if (j < r0 + 4) return 3'b110;
      else if (j < r0 + 8) return 3'b100;
      else                 return 3'b000;
   endfunction

   task automatic test_reset;
      rst        = 1'b1;
      ext_rst_n  = 1'b1;
      sw_rst_req = 1'b0;
      step(3);
      vectors++;
      if (rst_out !== 3'b111) begin
         errors++; $display("FAIL reset_rst_out got %b exp 111", rst_out);
      end
      vectors++;
      if (ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b exp 0", ready);
      end
      vectors++;
      if (rst_count !== 8'd0) begin
         errors++; $display("FAIL reset_count got %0d exp 0", rst_count);
      end
   endtask

   // Releases rst and follows the full settle + staged release; sw pulse
   // driven after edge sw_at (0 = none) must have no effect.
   task automatic powerup(input int sw_at);
      logic [2:0] exp;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 28; e++) begin
         step(1);
         sw_rst_req = (e == sw_at);
         exp = rel_pattern(e, SC);
         vectors++;
         if (rst_out !== exp) begin
            errors++; $display("FAIL powerup_rst_out edge %0d got %b exp %b", e, rst_out, exp);
         end
         vectors++;
         if (ready !== (exp == 3'b000)) begin
            errors++; $display("FAIL powerup_ready edge %0d got %b exp %b", e, ready, exp == 3'b000);
         end
      end
      vectors++;
      if (rst_count !== 8'd1) begin
         errors++; $display("FAIL powerup_count got %0d exp 1", rst_count);
      end
   endtask

   task automatic test_powerup;
      powerup(0);
   endtask

   // sw request from RUN; optional second pulse while in HOLD.
   task automatic sw_sequence(input int hold_sw_at, input logic [7:0] exp_cnt);
      logic [2:0] exp;
      sw_rst_req = 1'b1;
      for (int j = 1; j <= 15; j++) begin
         step(1);
         sw_rst_req = (j == hold_sw_at);
         exp = rel_pattern(j, 1 + HC);
         vectors++;
         if (rst_out !== exp) begin
            errors++; $display("FAIL sw_req_rst_out t+%0d got %b exp %b", j, rst_out, exp);
         end
         vectors++;
         if (ready !== (exp == 3'b000)) begin
            errors++; $display("FAIL sw_req_ready t+%0d got %b exp %b", j, ready, exp == 3'b000);
         end
      end
      vectors++;
      if (rst_count !== exp_cnt) begin
         errors++; $display("FAIL sw_req_count got %0d exp %0d", rst_count, exp_cnt);
      end
   endtask

   task automatic test_sw_req;
      sw_sequence(0, 8'd2);
   endtask

   task automatic test_hold_ignore;
      sw_sequence(3, 8'd3);
   endtask

   // Button low for L samples starting at edge s (j = edges since s).
   task automatic test_button(input int L, input bit asserts, input logic [7:0] exp_cnt);
      logic [2:0] exp;
      ext_rst_n = 1'b0;
      for (int j = 0; j <= L + 26; j++) begin
         step(1);
         ext_rst_n = (j + 1 < L) ? 1'b0 : 1'b1;
         if (!asserts || j < 11) exp = 3'b000;
         else                    exp = rel_pattern(j, L + 16);
         vectors++;
         if (rst_out !== exp) begin
            errors++; $display("FAIL button%0d_rst_out s+%0d got %b exp %b", L, j, rst_out, exp);
         end
         vectors++;
         if (ready !== (exp == 3'b000)) begin
            errors++; $display("FAIL button%0d_ready s+%0d got %b exp %b", L, j, ready, exp == 3'b000);
         end
      end
      vectors++;
      if (rst_count !== exp_cnt) begin
         errors++; $display("FAIL button%0d_count got %0d exp %0d", L, rst_count, exp_cnt);
      end
   endtask

   // Request sampled on the final-release edge sends the block back to HOLD.
   task automatic test_collision(input logic [7:0] cnt_before);
      logic [2:0] exp;
      sw_rst_req = 1'b1;
      for (int j = 1; j <= 29; j++) begin
         step(1);
         sw_rst_req = (j == 14);
         exp = (j < 15) ? rel_pattern(j, 7) : rel_pattern(j, 21);
         vectors++;
         if (rst_out !== exp) begin
            errors++; $display("FAIL collision_rst_out t+%0d got %b exp %b", j, rst_out, exp);
         end
         vectors++;
         if (ready !== (exp == 3'b000)) begin
            errors++; $display("FAIL collision_ready t+%0d got %b exp %b", j, ready, exp == 3'b000);
         end
         if (j == 15) begin
            vectors++;
            if (rst_count !== cnt_before) begin
               errors++; $display("FAIL collision_count_hold got %0d exp %0d", rst_count, cnt_before);
            end
         end
      end
      vectors++;
      if (rst_count !== cnt_before + 8'd1) begin
         errors++; $display("FAIL collision_count_end got %0d exp %0d", rst_count, cnt_before + 8'd1);
      end
   endtask

   task automatic test_async_reset;
      logic [2:0] exp;
      sw_rst_req = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step(1);
         sw_rst_req = 1'b0;
         exp = rel_pattern(j, 7);
         vectors++;
         if (rst_out !== exp) begin
            errors++; $display("FAIL async_pre_rst_out t+%0d got %b exp %b", j, rst_out, exp);
         end
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (rst_out !== 3'b111) begin
         errors++; $display("FAIL async_rst_out got %b exp 111", rst_out);
      end
      vectors++;
      if (ready !== 1'b0) begin
         errors++; $display("FAIL async_ready got %b exp 0", ready);
      end
      vectors++;
      if (rst_count !== 8'd0) begin
         errors++; $display("FAIL async_count got %0d exp 0", rst_count);
      end
      powerup(0);
   endtask

   task automatic test_settle_ignore;
      rst = 1'b1;
      step(2);
      powerup(18);
   endtask

   task automatic test_saturate;
      for (int i = 0; i < 300; i++) begin
         sw_rst_req = 1'b1;
         step(1);
         sw_rst_req = 1'b0;
         step(14);
         if (i == 252) begin
            vectors++;
            if (rst_count !== 8'd254) begin
               errors++; $display("FAIL saturate_254 got %0d exp 254", rst_count);
            end
         end
      end
      vectors++;
      if (rst_count !== 8'd255) begin
         errors++; $display("FAIL saturate_count got %0d exp 255", rst_count);
      end
      vectors++;
      if (rst_out !== 3'b000 || ready !== 1'b1) begin
         errors++; $display("FAIL saturate_run got rst_out %b ready %b exp 000 1", rst_out, ready);
      end
   endtask

   initial begin
      #300us;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_powerup();
      test_sw_req();
      test_hold_ignore();
      test_button(5, 1'b0, 8'd3);
      test_button(12, 1'b1, 8'd4);
      test_button(100, 1'b1, 8'd5);
      test_collision(8'd5);
      test_async_reset();
      test_settle_ignore();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
